// File: rtl/onehot_arb_mux.sv
// onehot_arb_mux: registered N-to-1 channel mux with round-robin arbitration.
//
// An internal arbiter picks one valid input per cycle. The search starts at
// the round-robin pointer and wraps. The one-hot grant drives an AND-OR mux,
// and the mux feeds a single output register with a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid[INPUTS]     per-channel beat valid
//   in_ready[INPUTS]     per-channel accept (one-hot or zero)
//   in_data[INPUTS]      per-channel data (unpacked array of WIDTH bits)
//   in_last[INPUTS]      per-channel end-of-packet flag
//   out_valid/out_ready  output register handshake
//   out_data, out_last   registered data and last flag of the granted beat
//   out_sel              registered one-hot grant that produced out_data
//
// Optional build macro ONEHOT_ARB_MUX_LOCK_EN:
//   The arbiter locks to a channel from its first non-last beat until that
//   channel's last beat is accepted. The pointer advances only on that
//   releasing beat.

// Per-lane gate: passes {last, data} only when this lane holds the grant.
module onehot_arb_mux_lane #(
    parameter int WIDTH = 8
) (
    input  logic             gnt,
    input  logic [WIDTH-1:0] data,
    input  logic             last,
    output logic [WIDTH:0]   gated
);
    assign gated = {last, data} & {(WIDTH+1){gnt}};
endmodule

module onehot_arb_mux #(
    parameter int INPUTS = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] in_valid,
    output logic [INPUTS-1:0] in_ready,
    input  logic [WIDTH-1:0]  in_data [INPUTS],
    input  logic [INPUTS-1:0] in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [INPUTS-1:0] out_sel,
    output logic              out_last
);
    localparam int PW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    logic [PW-1:0]               ptr;
    logic [PW-1:0]               win;
    logic [PW-1:0]               ptr_nxt;
    logic                        found;
    logic [INPUTS-1:0]           elig;
    logic [INPUTS-1:0]           gnt;
    logic                        load;
    logic                        accept;
    logic [INPUTS-1:0][WIDTH:0]  lane_out;
    logic [WIDTH:0]              mux_out;
    logic [WIDTH-1:0]            mux_data;
    logic                        mux_last;

`ifdef ONEHOT_ARB_MUX_LOCK_EN
    logic          locked;
    logic [PW-1:0] lock_ch;

    // While locked, only the owning channel may compete, even when it is idle.
    always_comb begin
        elig = in_valid;
        if (locked) elig = in_valid & (INPUTS'(1) << lock_ch);
    end
`else
    assign elig = in_valid;
`endif

    // Rotating priority is split into two passes. The first pass covers
    // channels at or above ptr. The second covers the wrapped region below
    // ptr, and it only matters when the first pass found nothing.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int c = 0; c < INPUTS; c++) begin
            if (!found && elig[c] && (c >= int'(ptr))) begin
                found = 1'b1;
                win   = PW'(c);
            end
        end
        for (int c = 0; c < INPUTS; c++) begin
            if (!found && elig[c]) begin
                found = 1'b1;
                win   = PW'(c);
            end
        end
    end

    assign gnt      = found ? (INPUTS'(1) << win) : '0;
    assign load     = !out_valid || out_ready;
    assign in_ready = load ? gnt : '0;
    assign accept   = load && found;
    assign ptr_nxt  = (win == PW'(INPUTS - 1)) ? '0 : win + 1'b1;

    // AND-OR mux: each lane gates its own beat, and the gated beats are OR-ed.
    for (genvar i = 0; i < INPUTS; i++) begin : g_lane
        onehot_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
            .gnt   (gnt[i]),
            .data  (in_data[i]),
            .last  (in_last[i]),
            .gated (lane_out[i])
        );
    end

    always_comb begin
        mux_out = '0;
        for (int i = 0; i < INPUTS; i++) mux_out = mux_out | lane_out[i];
    end

    assign mux_data = mux_out[WIDTH-1:0];
    assign mux_last = mux_out[WIDTH];

    // Output register. Reloading while draining keeps a full one-beat/cycle rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= gnt;
            out_last  <= mux_last;
`ifdef ONEHOT_ARB_MUX_LOCK_EN
            if (mux_last) ptr <= ptr_nxt;
`else
            ptr       <= ptr_nxt;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ONEHOT_ARB_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            locked  <= !mux_last;
            lock_ch <= win;
        end
    end
`endif

endmodule

// File: doc/onehot_arb_mux.md
Name: onehot_arb_mux

Overview:
- Registered N-to-1 channel mux with built-in round-robin arbitration and valid/ready handshakes on every input and on the output.
- The arbiter generates the one-hot select internally. It drives an AND-OR one-hot mux, and the mux feeds a single output register stage.
- Used wherever several producers share one downstream consumer, e.g. merging request streams into a single pipeline.

Parameters:
- INPUTS, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  INPUTS  per-channel valid; bit i belongs to channel i.
- in_ready  output  INPUTS  per-channel ready; at most one bit set per cycle.
- in_data  input  WIDTH x INPUTS (unpacked array [INPUTS])  per-channel data.
- in_last  input  INPUTS  per-channel end-of-packet flag.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  INPUTS  registered one-hot grant of the channel that produced out_data.
- out_last  output  1  registered in_last of the granted beat.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - Round-robin pointer ptr=0, so channel 0 has highest priority.
  - Lock state cleared.
- Load condition: load = !out_valid || out_ready.
- Arbitration (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping modulo INPUTS.
  - The first set bit is the winner; gnt is the one-hot of the winner.
  - gnt is all-zero when in_valid is all-zero.
- in_ready = gnt when load=1, else all-zero.
  - Depends on in_valid and out_ready combinationally.
  - Producers must not make in_valid depend on in_ready.
- Mux: AND-OR of in_data/in_last with gnt. An all-zero gnt yields zero data.
- Transfer in: the winner beat is accepted when load=1 and |gnt. On that edge:
  - out_data, out_last and out_sel load the winner's values.
  - out_valid<=1.
  - ptr<=(winner+1) mod INPUTS.
- Transfer out: out_valid && out_ready.
  - If no new beat is accepted in the same cycle, out_valid<=0.
  - out_data, out_sel and out_last hold their last values.
- Simultaneous out transfer and in acceptance: the register reloads and out_valid stays 1. This gives full throughput of one beat/cycle.
- Stall: out_valid=1 && !out_ready.
  - in_ready all-zero.
  - Output register and ptr hold.
  - Inputs must hold in_valid/in_data stable until accepted.
- Latency: accepted input beat appears at the output exactly 1 cycle later.
- Fairness: a continuously valid channel is granted within INPUTS accepted beats.
- Pointer wrap: when winner=INPUTS-1, ptr becomes 0.
- No accepted beat: ptr unchanged.
- Reset mid-operation: a beat held in the output register is discarded; out_valid=0 immediately (async).
- Stable-arb invariant: while stalled, gnt may change as in_valid changes. No beat is consumed until load=1.

Optional Feature:
- Macro: ONEHOT_ARB_MUX_LOCK_EN.
- Defined (packet lock):
  - After accepting a beat from channel i with in_last[i]=0, the arbiter locks to i.
  - While locked, only in_valid[i] is considered; other channels see in_ready=0 even if i is idle.
  - The lock releases on the edge that accepts a beat from i with in_last[i]=1.
  - ptr advances only on that releasing beat.
  - Reset clears the lock.
- Undefined:
  - in_last is only passed through to out_last.
  - Arbitration is per beat and the lock logic is not compiled.

Test Plan (INPUTS=4, WIDTH=8):
1. Reset, then in_valid=4'b0000 for 5 cycles -> out_valid=0, out_data=8'h00, out_sel=0, in_ready=0 throughout.
2. in_valid=4'b1111 for 8 cycles, in_data[i]=8'h10+i, out_ready=1 -> out_data sequence 10,11,12,13,10,11,12,13 starting 1 cycle after the first edge; out_sel one-hot matches each beat.
3. Only ch2 valid with data 8'hA5, out_ready=0 for 3 cycles, then 1 -> one beat accepted; in_ready=0 during the stall; out_data=A5 held; out_valid drops 1 cycle after out_ready rises.
4. ptr=3 (after ch2 win), in_valid=4'b1001 -> ch3 wins, then ch0; ptr wraps to 0, then 1.
5. Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 without a clock edge; after release, ch0 has priority over ch1 when both are valid.
6. (LOCK_EN) ch1 sends 3 beats with in_last=0,0,1 while ch0 is continuously valid -> all 3 ch1 beats are output consecutively; ch0 is granted only on the next beat after ch1's last beat.
